// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with valid/ready handshake, flush-to-bubble
// and saturating stall counter. Define PIPE_STAGE_SKID_EN for the 2-entry skid build (registered in_ready_PR).
module pipe_stage_reg #(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = 16,
    parameter logic [DATA_W-1:0] NOP_DATA = '0,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk_PR,
    input  logic              rst_n_PR,
    input  logic              flush_PR,
    input  logic              in_valid_PR,
    output logic              in_ready_PR,
    input  logic [DATA_W-1:0] in_data_PR,
    input  logic [CTRL_W-1:0] in_ctrl_PR,
    output logic              out_valid_PR,
    input  logic              out_ready_PR,
    output logic [DATA_W-1:0] out_data_PR,
    output logic [CTRL_W-1:0] out_ctrl_PR,
    output logic [CNT_W-1:0]  stall_cnt_PR
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic [CTRL_W-1:0] ctrl_p0;
    logic [CNT_W-1:0]  stall_cnt_p0;
    logic              accept;
    logic              emit;

    // An input presented during a flush is never taken, even with in_ready_PR high.
    assign accept = in_valid_PR && in_ready_PR && !flush_PR;
    assign emit   = vld_p0 && out_ready_PR;

    assign out_valid_PR = vld_p0;
    assign out_data_PR  = data_p0;
    assign out_ctrl_PR  = ctrl_p0;
    assign stall_cnt_PR = stall_cnt_p0;

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t            state;
    logic              rdy_p0;
    logic [DATA_W-1:0] skid_data_p0;
    logic [CTRL_W-1:0] skid_ctrl_p0;

    assign in_ready_PR = rdy_p0;

    // Main register feeds the outputs; the skid register absorbs the one entry
    // that arrives in the cycle downstream first stalls.
    always_ff @(posedge clk_PR or negedge rst_n_PR) begin
        if (!rst_n_PR) begin
            state        <= S_EMPTY;
            vld_p0       <= 1'b0;
            rdy_p0       <= 1'b1;
            data_p0      <= NOP_DATA;
            ctrl_p0      <= NOP_CTRL;
            skid_data_p0 <= NOP_DATA;
            skid_ctrl_p0 <= NOP_CTRL;
        end else if (flush_PR) begin
            state        <= S_EMPTY;
            vld_p0       <= 1'b0;
            rdy_p0       <= 1'b1;
            data_p0      <= NOP_DATA;
            ctrl_p0      <= NOP_CTRL;
            skid_data_p0 <= NOP_DATA;
            skid_ctrl_p0 <= NOP_CTRL;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        state   <= S_ONE;
                        vld_p0  <= 1'b1;
                        data_p0 <= in_data_PR;
                        ctrl_p0 <= in_ctrl_PR;
                    end
                end
                S_ONE: begin
                    if (accept && emit) begin
                        data_p0 <= in_data_PR;
                        ctrl_p0 <= in_ctrl_PR;
                    end else if (accept) begin
                        state        <= S_TWO;
                        rdy_p0       <= 1'b0;
                        skid_data_p0 <= in_data_PR;
                        skid_ctrl_p0 <= in_ctrl_PR;
                    end else if (emit) begin
                        state   <= S_EMPTY;
                        vld_p0  <= 1'b0;
                        data_p0 <= NOP_DATA;
                        ctrl_p0 <= NOP_CTRL;
                    end
                end
                S_TWO: begin
                    if (emit) begin
                        state        <= S_ONE;
                        rdy_p0       <= 1'b1;
                        data_p0      <= skid_data_p0;
                        ctrl_p0      <= skid_ctrl_p0;
                        skid_data_p0 <= NOP_DATA;
                        skid_ctrl_p0 <= NOP_CTRL;
                    end
                end
                default: begin
                    state   <= S_EMPTY;
                    vld_p0  <= 1'b0;
                    rdy_p0  <= 1'b1;
                    data_p0 <= NOP_DATA;
                    ctrl_p0 <= NOP_CTRL;
                end
            endcase
        end
    end
`else
    // Single register: ready whenever the held entry leaves this cycle or there is none.
    assign in_ready_PR = !vld_p0 || out_ready_PR;

    always_ff @(posedge clk_PR or negedge rst_n_PR) begin
        if (!rst_n_PR) begin
            vld_p0  <= 1'b0;
            data_p0 <= NOP_DATA;
            ctrl_p0 <= NOP_CTRL;
        end else if (flush_PR) begin
            vld_p0  <= 1'b0;
            data_p0 <= NOP_DATA;
            ctrl_p0 <= NOP_CTRL;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            data_p0 <= in_data_PR;
            ctrl_p0 <= in_ctrl_PR;
        end else if (emit) begin
            vld_p0  <= 1'b0;
            data_p0 <= NOP_DATA;
            ctrl_p0 <= NOP_CTRL;
        end
    end
`endif

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk_PR or negedge rst_n_PR) begin
        if (!rst_n_PR) begin
            stall_cnt_p0 <= '0;
        end else if (vld_p0 && !out_ready_PR && !flush_PR && (stall_cnt_p0 != CNT_MAX)) begin
            stall_cnt_p0 <= stall_cnt_p0 + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Follows PIPE_STAGE_SKID_EN like the DUT.
module tb_pipe_stage_reg;
    localparam int                DATA_W = 32;
    localparam int                CTRL_W = 8;
    localparam int                CNT_W  = 4;
    localparam logic [DATA_W-1:0] NOP_D  = 32'hDEAD_BEEF;
    localparam logic [CTRL_W-1:0] NOP_C  = 8'h5A;
    localparam int                CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk_PR = 1'b0;
    logic              rst_n_PR = 1'b1;
    logic              flush_PR = 1'b0;
    logic              in_valid_PR = 1'b0;
    logic              in_ready_PR;
    logic [DATA_W-1:0] in_data_PR = '0;
    logic [CTRL_W-1:0] in_ctrl_PR = '0;
    logic              out_valid_PR;
    logic              out_ready_PR = 1'b0;
    logic [DATA_W-1:0] out_data_PR;
    logic [CTRL_W-1:0] out_ctrl_PR;
    logic [CNT_W-1:0]  stall_cnt_PR;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_DATA(NOP_D), .NOP_CTRL(NOP_C), .CNT_W(CNT_W)
    ) dut (
        .clk_PR(clk_PR), .rst_n_PR(rst_n_PR), .flush_PR(flush_PR),
        .in_valid_PR(in_valid_PR), .in_ready_PR(in_ready_PR),
        .in_data_PR(in_data_PR), .in_ctrl_PR(in_ctrl_PR),
        .out_valid_PR(out_valid_PR), .out_ready_PR(out_ready_PR),
        .out_data_PR(out_data_PR), .out_ctrl_PR(out_ctrl_PR),
        .stall_cnt_PR(stall_cnt_PR)
    );

    always #10 clk_PR = ~clk_PR;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of capacity 1 (plain) or 2 (skid).
    logic [CTRL_W+DATA_W-1:0] q[$];
    int m_cnt = 0;
    bit m_acc, m_emt;

    function automatic bit m_ready();
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || out_ready_PR;
    endfunction

    initial forever begin
        @(posedge clk_PR or negedge rst_n_PR);
        if (!rst_n_PR) begin
            q.delete();
            m_cnt = 0;
        end else if (flush_PR) begin
            q.delete();
        end else begin
            m_acc = in_valid_PR && m_ready();
            m_emt = (q.size() > 0) && out_ready_PR;
            if ((q.size() > 0) && !out_ready_PR && (m_cnt < CNT_MAX)) m_cnt++;
            if (m_emt) void'(q.pop_front());
            if (m_acc) q.push_back({in_ctrl_PR, in_data_PR});
        end
    end

    initial forever begin
        @(negedge clk_PR);
        chk("m_valid", 64'(out_valid_PR), 64'(q.size() > 0));
        chk("m_data", 64'(out_data_PR), 64'((q.size() > 0) ? q[0][DATA_W-1:0] : NOP_D));
        chk("m_ctrl", 64'(out_ctrl_PR), 64'((q.size() > 0) ? q[0][CTRL_W+DATA_W-1:DATA_W] : NOP_C));
        chk("m_ready", 64'(in_ready_PR), 64'(m_ready()));
        chk("m_cnt", 64'(stall_cnt_PR), 64'(m_cnt));
    end

    task automatic cyc();
        @(negedge clk_PR);
        #2;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
        in_valid_PR  = v;
        in_data_PR   = d;
        in_ctrl_PR   = d[CTRL_W-1:0];
        out_ready_PR = r;
        flush_PR     = f;
    endtask

    initial begin
        #1 rst_n_PR = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", 64'(out_valid_PR), 64'd0);
        chk("rst_data", 64'(out_data_PR), 64'(NOP_D));
        chk("rst_ctrl", 64'(out_ctrl_PR), 64'(NOP_C));
        chk("rst_ready", 64'(in_ready_PR), 64'd1);
        chk("rst_cnt", 64'(stall_cnt_PR), 64'd0);
        rst_n_PR = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), 1'b1, 1'b0);
            cyc();
            chk("stream_data", 64'(out_data_PR), 64'(i));
            chk("stream_valid", 64'(out_valid_PR), 64'd1);
        end
        chk("stream_cnt", 64'(stall_cnt_PR), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        chk("drain_valid", 64'(out_valid_PR), 64'd0);

        // Downstream stalls for three cycles
        drive(1'b1, 32'h11, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 32'h12, 1'b0, 1'b0);
        #1;
        chk("stall_ready_same", 64'(in_ready_PR), SKID ? 64'd1 : 64'd0);
        cyc();
        chk("stall_ready_next", 64'(in_ready_PR), 64'd0);
        drive(1'b1, 32'h13, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("stall_cnt3", 64'(stall_cnt_PR), 64'd3);
        chk("stall_head", 64'(out_data_PR), 64'h11);
        chk("stall_ready", 64'(in_ready_PR), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        chk("release_valid", 64'(out_valid_PR), SKID ? 64'd1 : 64'd0);
        chk("release_data", 64'(out_data_PR), SKID ? 64'h12 : 64'(NOP_D));
        cyc();
        chk("release_empty", 64'(out_valid_PR), 64'd0);

        // Flush while full, with 0xA5 offered in the flush cycle
        drive(1'b1, 32'h21, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        cyc();
        chk("prefl_cnt", 64'(stall_cnt_PR), 64'd4);
        drive(1'b1, 32'hA5, 1'b0, 1'b1);
        cyc();
        chk("flush_valid", 64'(out_valid_PR), 64'd0);
        chk("flush_data", 64'(out_data_PR), 64'(NOP_D));
        chk("flush_ctrl", 64'(out_ctrl_PR), 64'(NOP_C));
        chk("flush_cnt", 64'(stall_cnt_PR), 64'd4);
        chk("flush_ready", 64'(in_ready_PR), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        chk("postfl_valid", 64'(out_valid_PR), 64'd0);

        // Long stall saturates the counter
        drive(1'b1, 32'h31, 1'b1, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (20) cyc();
        chk("sat_cnt", 64'(stall_cnt_PR), 64'd15);
        chk("sat_data", 64'(out_data_PR), 64'h31);

        // Asynchronous reset between edges while holding one entry
        #1 rst_n_PR = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid_PR), 64'd0);
        chk("arst_data", 64'(out_data_PR), 64'(NOP_D));
        chk("arst_ctrl", 64'(out_ctrl_PR), 64'(NOP_C));
        chk("arst_ready", 64'(in_ready_PR), 64'd1);
        chk("arst_cnt", 64'(stall_cnt_PR), 64'd0);
        cyc();
        rst_n_PR = 1'b1;

        repeat (500) begin
            drive(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0));
            cyc();
        end

        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
